split_ram: RTL and testbench

Fork block that undoes a channel concat: it takes one 2×C-channel pixel stream and splits it into two C-channel streams. The upper half goes straight to the trunk. The lower half is buffered in a BRAM ring and replayed in order when the branch consumer requests it. It sits wherever one layer's output feeds both a trunk layer and a deferred branch path, and is the producer-side counterpart of the concat merge.

---
 rtl/split_ram_pkg.sv | 23 ++
 rtl/split_ram_bram.sv | 27 ++
 rtl/split_ram.sv | 127 ++++++++++++
 tb/tb_split_ram.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/split_ram_pkg.sv
// Shared constants and helpers for the split/concat RAM blocks.
// Buffer depth, pointer widths and the ring-pointer wrap live here.
package split_ram_pkg;

  function automatic int unsigned depth_of(input int unsigned size);
    return size * size;
  endfunction

  // Pointers and occupancy must hold 0..DEPTH inclusive.
  function automatic int unsigned ptr_width_of(input int unsigned size);
    return $clog2(size * size + 1);
  endfunction

  // Index width for addressing exactly DEPTH RAM words.
  function automatic int unsigned idx_width_of(input int unsigned size);
    return (size * size > 1) ? $clog2(size * size) : 1;
  endfunction

  function automatic int unsigned ptr_wrap(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/split_ram_bram.sv
// Simple dual-port RAM with one write port and a registered read port.
// Contents are intentionally not reset so the array maps onto block RAM.
module split_ram_bram #(
  parameter int DEPTH = 1,
  parameter int AW    = 1,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/split_ram.sv
// Splits a 2C-channel stream: upper half to trunk, lower half ring-buffered for replay.
// Optional sticky protocol error flag built only when SPLIT_RAM_ERR_EN is defined.
module split_ram
  import split_ram_pkg::*;
#(
  parameter int N              = 8,
  parameter int INPUT_CHANNEL  = 1,
  parameter int INPUT_SIZE     = 1,
  parameter int RAM_ADDR_WIDTH = ptr_width_of(INPUT_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_vld,
  input  logic [2*INPUT_CHANNEL*N-1:0]  din,
  output logic                          trunk_vld,
  output logic [INPUT_CHANNEL*N-1:0]    trunk_dout,
  input  logic                          branch_req,
  output logic                          branch_vld,
  output logic [INPUT_CHANNEL*N-1:0]    branch_dout,
  output logic                          frame_done,
  output logic                          buf_empty,
  output logic                          buf_full,
  output logic                          err
);

  localparam int unsigned DEPTH = depth_of(INPUT_SIZE);
  localparam int          IDX_W = idx_width_of(INPUT_SIZE);
  localparam int          HW    = INPUT_CHANNEL * N;
  localparam int          AW    = RAM_ADDR_WIDTH;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] count;
  logic [AW-1:0] count_next;
  logic [AW-1:0] frm_cnt;
  logic          rd_en_d0;
  logic [HW-1:0] rd_data;
  logic          wr_acc;
  logic          rd_acc;
  logic          is_full;
  logic          is_empty;

  assign is_full  = (count == AW'(DEPTH));
  assign is_empty = (count == '0);
  assign wr_acc   = din_vld && !is_full;
  assign rd_acc   = branch_req && !is_empty;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + AW'(1);
    else if (rd_acc && !wr_acc) count_next = count - AW'(1);
  end

  split_ram_bram #(
    .DEPTH (DEPTH),
    .AW    (IDX_W),
    .DW    (HW)
  ) u_bram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[IDX_W-1:0]),
    .wr_data (din[HW-1:0]),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // Trunk path ignores buffer state entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trunk_vld  <= 1'b0;
      trunk_dout <= '0;
    end else begin
      trunk_vld <= din_vld;
      if (din_vld) trunk_dout <= din[2*HW-1:HW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      buf_empty <= 1'b1;
      buf_full  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= AW'(ptr_wrap(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= AW'(ptr_wrap(32'(rd_ptr), DEPTH));
      count     <= count_next;
      buf_empty <= (count_next == '0);
      buf_full  <= (count_next == AW'(DEPTH));
    end
  end

  // Replay pipeline: RAM read stage, then output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_d0    <= 1'b0;
      branch_vld  <= 1'b0;
      branch_dout <= '0;
      frm_cnt     <= '0;
      frame_done  <= 1'b0;
    end else begin
      rd_en_d0   <= rd_acc;
      branch_vld <= rd_en_d0;
      frame_done <= 1'b0;
      if (rd_en_d0) begin
        branch_dout <= rd_data;
        frame_done  <= (frm_cnt == AW'(DEPTH - 1));
        frm_cnt     <= AW'(ptr_wrap(32'(frm_cnt), DEPTH));
      end
    end
  end

`ifdef SPLIT_RAM_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((din_vld && is_full) || (branch_req && is_empty)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_split_ram.sv
// Scoreboard bench for split_ram with C=1, N=8, INPUT_SIZE=2 (DEPTH=4).
module tb_split_ram;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic [15:0] din = '0;
  logic        trunk_vld;
  logic [7:0]  trunk_dout;
  logic        branch_req = 1'b0;
  logic        branch_vld;
  logic [7:0]  branch_dout;
  logic        frame_done;
  logic        buf_empty;
  logic        buf_full;
  logic        err;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         due;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_m[$];
  int         frm_m;
  logic       err_m;
  logic [7:0] trunk_m;
  int         cyc;
  int         n_checks;
  int         n_fail;

  split_ram #(
    .N             (8),
    .INPUT_CHANNEL (1),
    .INPUT_SIZE    (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din_vld     (din_vld),
    .din         (din),
    .trunk_vld   (trunk_vld),
    .trunk_dout  (trunk_dout),
    .branch_req  (branch_req),
    .branch_vld  (branch_vld),
    .branch_dout (branch_dout),
    .frame_done  (frame_done),
    .buf_empty   (buf_empty),
    .buf_full    (buf_full),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Replayed elements are compared in order against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (branch_vld) begin
      if (exp_q.size() == 0) begin
        check("spurious_branch_vld", 32'(branch_vld), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("branch_dout", 32'(branch_dout), 32'(e.data));
        check("frame_done", 32'(frame_done), 32'(e.last));
        check("branch_latency", 32'(cyc), 32'(e.due));
        $display("branch out %02h frame_done=%0d", branch_dout, frame_done);
      end
    end else if (rst_n) begin
      check("frame_done_idle", 32'(frame_done), 32'd0);
    end
  end

  task automatic step(input logic v, input logic [15:0] d, input logic r);
    logic wa;
    logic ra;
    exp_t e;
    din_vld    = v;
    din        = d;
    branch_req = r;
    wa = v && (fifo_m.size() != DEPTH);
    ra = r && (fifo_m.size() != 0);
    if (ra) begin
      e.data = fifo_m.pop_front();
      e.last = (frm_m == DEPTH - 1);
      e.due  = cyc + 2;
      exp_q.push_back(e);
      frm_m = (frm_m + 1) % DEPTH;
    end
    if (wa) fifo_m.push_back(d[7:0]);
`ifdef SPLIT_RAM_ERR_EN
    if ((v && !wa) || (r && !ra)) err_m = 1'b1;
`endif
    if (v) trunk_m = d[15:8];
    @(posedge clk);
    #1;
    $display("step vld=%0d din=%04h req=%0d -> trunk %0d/%02h full=%0d empty=%0d err=%0d",
             v, d, r, trunk_vld, trunk_dout, buf_full, buf_empty, err);
    check("trunk_vld", 32'(trunk_vld), 32'(v));
    check("trunk_dout", 32'(trunk_dout), 32'(trunk_m));
    check("buf_full", 32'(buf_full), 32'(fifo_m.size() == DEPTH));
    check("buf_empty", 32'(buf_empty), 32'(fifo_m.size() == 0));
    check("err", 32'(err), 32'(err_m));
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    din_vld    = 1'b0;
    din        = '0;
    branch_req = 1'b0;
    exp_q.delete();
    fifo_m.delete();
    frm_m   = 0;
    err_m   = 1'b0;
    trunk_m = '0;
    #1;
    check("rst_trunk_vld", 32'(trunk_vld), 32'd0);
    check("rst_trunk_dout", 32'(trunk_dout), 32'd0);
    check("rst_branch_vld", 32'(branch_vld), 32'd0);
    check("rst_branch_dout", 32'(branch_dout), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_buf_empty", 32'(buf_empty), 32'd1);
    check("rst_buf_full", 32'(buf_full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    $display("reset applied");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) step(1'b0, 16'h0000, 1'b0);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] frame_a [4];
    logic [15:0] frame_e [4];
    logic [15:0] frame_f [4];
    frame_a = '{16'hA1B1, 16'hA2B2, 16'hA3B3, 16'hA4B4};
    frame_e = '{16'hE1F1, 16'hE2F2, 16'hE3F3, 16'hE4F4};
    frame_f = '{16'h1151, 16'h2252, 16'h3353, 16'h4454};
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    @(posedge clk);
    #1;
    do_reset();
    step(1'b0, 16'h0000, 1'b0);

    // Fill, overflow attempt, then a full replay frame.
    foreach (frame_a[i]) step(1'b1, frame_a[i], 1'b0);
    step(1'b1, 16'hC5D5, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
    drain();

    // Concurrent traffic at full and at mid occupancy.
    foreach (frame_e[i]) step(1'b1, frame_e[i], 1'b0);
    step(1'b1, 16'h9999, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h7A7B, 1'b1);
    step(1'b1, 16'h6C6D, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1);
    drain();

    // Requests while empty, and simultaneous write/read at empty.
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h5A5B, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    drain();

    // Reset mid-drain, then a clean frame from address 0.
    do_reset();
    foreach (frame_a[i]) step(1'b1, frame_a[i], 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    do_reset();
    foreach (frame_f[i]) step(1'b1, frame_f[i], 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
